cmp_persist_monitor: RTL and testbench
======================================

// Module: cmp_persist_monitor
// PURPOSE
//  Consumes the one-hot lesser/greater/equal result stream of the N-bit comparator
//  and filters it into a stable three-level status.
//  A status change is accepted only after PERSIST consecutive valid samples agree.
//  Counts upward and downward crossings and flags malformed comparator results.
//  Sits directly downstream of the comparator; feeds alarm/interrupt logic.
// PARAMETERS
//  PERSIST  4  consecutive agreeing samples needed to change state (1..255; 1 = no filtering)
//  CNT_W    8  width of each crossing counter (saturating)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      reset, asynchronous assert, active-low
//  in_valid     in   1      lesser/greater/equal are valid this cycle
//  lesser       in   1      comparator a<b
//  greater      in   1      comparator a>b
//  equal        in   1      comparator a==b
//  clear        in   1      synchronous clear of both counters and err_o
//  state_o      out  2      filtered status: 2'b01 LESS, 2'b00 EQUAL, 2'b10 GREATER
//  cross_pulse  out  1      one-cycle pulse when state_o changes
//  up_cnt       out  CNT_W  count of upward transitions
//  down_cnt     out  CNT_W  count of downward transitions
//  err_o        out  1      sticky: a valid sample was not one-hot
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state_o=EQUAL, candidate=EQUAL, persist count=0,
//    cross_pulse=0, up_cnt=0, down_cnt=0, err_o=0. Reset mid-filter discards partial count.
//  - All outputs are registered. A decision is made on the edge that samples in_valid=1.
//    state_o and cross_pulse update on that same edge, so they are visible the cycle after
//    the deciding sample.
//  - Sample class: LESS/EQUAL/GREATER from the single asserted flag.
//  - in_valid=0: no state change. Persist count and candidate hold (gaps do not break a run).
//  - Malformed sample (in_valid=1, flags not exactly one-hot, incl. all-zero):
//    - set err_o;
//    - the sample is ignored entirely (count/candidate/state hold).
//  - Persistence filter FSM, states LESS/EQUAL/GREATER, on each well-formed sample s:
//    - s == state_o: count<=0, candidate<=s.
//    - s != state_o and s == candidate:
//      - count+1 == PERSIST: state_o<=s, count<=0, cross_pulse<=1;
//      - else count<=count+1.
//    - s != state_o and s != candidate: candidate<=s, count<=1.
//      - If PERSIST==1, transition immediately as above.
//  - Any LESS<->GREATER transition is direct. No forced pass through EQUAL.
//  - Rank order is LESS < EQUAL < GREATER.
//    - A transition to a higher rank increments up_cnt.
//    - A transition to a lower rank increments down_cnt.
//    - Both counters saturate at 2^CNT_W-1; no wrap.
//  - cross_pulse is 0 in every cycle without a transition (never held two cycles by one event).
//  - clear=1: up_cnt<=0, down_cnt<=0, err_o<=0. Filter and state_o are not affected.
//    - clear with a transition in the same cycle: counters end at 0.
//      state_o still changes and cross_pulse still fires.
//    - clear with a malformed sample in the same cycle: err_o ends at 0 (clear wins).
// TESTING
//  1. Reset, then 4 valid greater samples (PERSIST=4):
//     - state_o stays 00 after samples 1-3;
//     - state_o becomes 10 and cross_pulse=1 for exactly one cycle after sample 4;
//     - up_cnt=1.
//  2. From GREATER: 3 lesser, 1 equal, 4 lesser ->
//     - no change until the 4th lesser of the second run;
//     - then state_o=01, down_cnt=1.
//  3. Run of greater samples with in_valid gaps of 0-5 idle cycles between them ->
//     transition still occurs on the 4th valid sample.
//  4. in_valid=1 with {lesser,greater,equal}=3'b110 and then 3'b000 ->
//     - err_o=1 and stays 1;
//     - state_o and persist progress unchanged;
//     - clear pulse -> err_o=0.
//  5. CNT_W=2, force 5 upward transitions (LESS->EQUAL->GREATER cycles via LESS):
//     - up_cnt saturates at 3;
//     - clear in the same cycle as a transition -> counters read 0, cross_pulse=1.
//  6. Assert rst_n=0 asynchronously mid-run (count=3) -> outputs reset immediately;
//     after release, 3 more greater samples do not change state_o.

Source files
------------

// File: rtl/cmp_persist_monitor.sv
// Persistence filter for a one-hot lesser/greater/equal comparator stream.
// A new status is accepted only after PERSIST consecutive agreeing valid samples;
// upward/downward crossings are counted (saturating) and malformed samples are flagged.
module cmp_persist_monitor #(
  parameter int unsigned PERSIST = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             lesser,
  input  logic             greater,
  input  logic             equal,
  input  logic             clear,
  output logic [1:0]       state_o,
  output logic             cross_pulse,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt,
  output logic             err_o
);

  typedef enum logic [1:0] {
    StEqual   = 2'b00,
    StLess    = 2'b01,
    StGreater = 2'b10
  } status_e;

  localparam logic [8:0]       PersistLen = 9'(PERSIST);
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  // Rank order LESS < EQUAL < GREATER decides the crossing direction.
  function automatic logic [1:0] rank(status_e s);
    case (s)
      StLess:    rank = 2'd0;
      StEqual:   rank = 2'd1;
      StGreater: rank = 2'd2;
      default:   rank = 2'd1;
    endcase
  endfunction

  status_e          state_q, state_d;
  status_e          cand_q, cand_d;
  status_e          sample;
  logic [7:0]       cnt_q, cnt_d;
  logic [8:0]       run_len;
  logic             onehot, well, malformed, trans;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] up_q, up_d, down_q, down_d;
  logic             err_q, err_d;

  // Classify the incoming sample; odd parity minus all-three-set is exactly one-hot.
  always_comb begin
    onehot    = (lesser ^ greater ^ equal) & ~(lesser & greater & equal);
    well      = in_valid & onehot;
    malformed = in_valid & ~onehot;
    if (lesser) begin
      sample = StLess;
    end else if (greater) begin
      sample = StGreater;
    end else begin
      sample = StEqual;
    end
  end

  // State register: filter state, persist run, counters and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEqual;
      cand_q  <= StEqual;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      up_q    <= '0;
      down_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      up_q    <= up_d;
      down_q  <= down_d;
      err_q   <= err_d;
    end
  end

  // Next-state: extend or restart the candidate run and decide on a transition.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    trans   = 1'b0;
    // A sample that differs from the candidate starts a fresh run of length 1.
    run_len = (sample == cand_q) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;
    if (well) begin
      if (sample == state_q) begin
        cnt_d  = '0;
        cand_d = sample;
      end else begin
        cand_d = sample;
        if (run_len == PersistLen) begin
          state_d = sample;
          cnt_d   = '0;
          trans   = 1'b1;
        end else begin
          cnt_d = run_len[7:0];
        end
      end
    end
  end

  // Next-state for crossing pulse, saturating counters and sticky error; clear wins.
  always_comb begin
    pulse_d = trans;
    up_d    = up_q;
    down_d  = down_q;
    if (trans) begin
      if (rank(state_d) > rank(state_q)) begin
        if (up_q != CntMax) up_d = up_q + CntOne;
      end else begin
        if (down_q != CntMax) down_d = down_q + CntOne;
      end
    end
    err_d = err_q | malformed;
    if (clear) begin
      up_d   = '0;
      down_d = '0;
      err_d  = 1'b0;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    state_o     = state_q;
    cross_pulse = pulse_q;
    up_cnt      = up_q;
    down_cnt    = down_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_cmp_persist_monitor.sv
// Directed bench for cmp_persist_monitor: a vector table for the main filter
// behaviour plus hand sequences for gaps, async reset and counter saturation.
module tb_cmp_persist_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_v, a_l, a_g, a_e, a_clr;
  logic [1:0] a_state;
  logic       a_pulse;
  logic [7:0] a_up, a_dn;
  logic       a_err;
  logic       b_v, b_l, b_g, b_e, b_clr;
  logic [1:0] b_state;
  logic       b_pulse;
  logic [1:0] b_up, b_dn;
  logic       b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_persist_monitor #(.PERSIST(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_v), .lesser(a_l), .greater(a_g), .equal(a_e),
    .clear(a_clr), .state_o(a_state), .cross_pulse(a_pulse), .up_cnt(a_up),
    .down_cnt(a_dn), .err_o(a_err)
  );

  cmp_persist_monitor #(.PERSIST(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_v), .lesser(b_l), .greater(b_g), .equal(b_e),
    .clear(b_clr), .state_o(b_state), .cross_pulse(b_pulse), .up_cnt(b_up),
    .down_cnt(b_dn), .err_o(b_err)
  );

  typedef struct {
    logic       v, l, g, e, clr;
    logic [1:0] st;
    logic       pl;
    logic [7:0] up, dn;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, l, g, e, clr);
    a_v = v; a_l = l; a_g = g; a_e = e; a_clr = clr;
  endtask

  task automatic drive_b(input logic v, l, g, e, clr);
    b_v = v; b_l = l; b_g = g; b_e = e; b_clr = clr;
  endtask

  task automatic add(input logic v, l, g, e, clr, input logic [1:0] st, input logic pl,
                     input logic [7:0] up, dn, input logic er);
    vec_t t;
    t.v = v; t.l = l; t.g = g; t.e = e; t.clr = clr;
    t.st = st; t.pl = pl; t.up = up; t.dn = dn; t.er = er;
    vecs.push_back(t);
  endtask

  task automatic check_a(input string tag, input logic [1:0] st, input logic pl,
                         input logic [7:0] up, dn, input logic er);
    check({tag, " state"}, 32'(a_state), 32'(st));
    check({tag, " pulse"}, 32'(a_pulse), 32'(pl));
    check({tag, " up"},    32'(a_up),    32'(up));
    check({tag, " down"},  32'(a_dn),    32'(dn));
    check({tag, " err"},   32'(a_err),   32'(er));
  endtask

  initial begin
    int gaps[4];
    logic [1:0] b_seq[8];
    logic [1:0] b_up_exp[8];
    logic [1:0] b_dn_exp[8];

    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 2'b00, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Table: v l g e clr | state pulse up down err
    add(1,0,1,0,0, 2'b00,0,0,0,0);  // greater run 1..3
    add(1,0,1,0,0, 2'b00,0,0,0,0);
    add(1,0,1,0,0, 2'b00,0,0,0,0);
    add(1,0,1,0,0, 2'b10,1,1,0,0);  // 4th greater -> GREATER
    add(0,0,0,0,0, 2'b10,0,1,0,0);  // pulse lasts one cycle
    add(1,1,0,0,0, 2'b10,0,1,0,0);  // 3 lesser
    add(1,1,0,0,0, 2'b10,0,1,0,0);
    add(1,1,0,0,0, 2'b10,0,1,0,0);
    add(1,0,0,1,0, 2'b10,0,1,0,0);  // equal breaks the run
    add(1,1,0,0,0, 2'b10,0,1,0,0);
    add(1,1,0,0,0, 2'b10,0,1,0,0);
    add(1,1,0,0,0, 2'b10,0,1,0,0);
    add(1,1,0,0,0, 2'b01,1,1,1,0);  // 4th lesser of second run
    add(0,0,0,0,0, 2'b01,0,1,1,0);
    add(1,0,1,0,0, 2'b01,0,1,1,0);  // greater run 1,2
    add(1,0,1,0,0, 2'b01,0,1,1,0);
    add(1,1,1,0,0, 2'b01,0,1,1,1);  // malformed 110
    add(1,0,0,0,0, 2'b01,0,1,1,1);  // malformed 000
    add(1,0,1,0,0, 2'b01,0,1,1,1);  // run 3, malformed ignored
    add(1,0,1,0,0, 2'b10,1,2,1,1);  // run 4 -> GREATER
    add(0,0,0,0,1, 2'b10,0,0,0,0);  // clear
    add(1,1,1,1,1, 2'b10,0,0,0,0);  // malformed with clear: clear wins
    add(1,0,1,1,0, 2'b10,0,0,0,1);
    add(0,0,0,0,1, 2'b10,0,0,0,0);
    add(1,0,0,1,0, 2'b10,0,0,0,0);  // equal x3
    add(1,0,0,1,0, 2'b10,0,0,0,0);
    add(1,0,0,1,0, 2'b10,0,0,0,0);
    add(1,0,1,0,0, 2'b10,0,0,0,0);  // sample equal to state restarts run
    add(1,0,0,1,0, 2'b10,0,0,0,0);
    add(1,0,0,1,0, 2'b10,0,0,0,0);
    add(1,0,0,1,0, 2'b10,0,0,0,0);
    add(1,0,0,1,0, 2'b00,1,0,1,0);  // 4th equal -> EQUAL, down

    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].v, vecs[i].l, vecs[i].g, vecs[i].e, vecs[i].clr);
      tick();
      check_a($sformatf("vec%0d", i), vecs[i].st, vecs[i].pl, vecs[i].up, vecs[i].dn,
              vecs[i].er);
    end

    // Greater samples separated by idle gaps still transition on the 4th.
    gaps = '{2, 5, 0, 3};
    for (int i = 0; i < 4; i++) begin
      drive_a(0, 0, 0, 0, 0);
      for (int k = 0; k < gaps[i]; k++) tick();
      drive_a(1, 0, 1, 0, 0);
      tick();
      if (i < 3) begin
        check($sformatf("gap%0d state", i), 32'(a_state), 32'(2'b00));
      end else begin
        check_a("gap final", 2'b10, 1, 1, 1, 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 0, 0, 1, 0);
      tick();
    end
    check_a("back to equal", 2'b00, 1, 1, 2, 0);

    // Async reset mid-run discards the partial count.
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 0, 1, 0, 0);
      tick();
    end
    check("prerst state", 32'(a_state), 32'(2'b00));
    #2 rst_n = 1'b0;
    #1;
    check_a("async rst", 2'b00, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postrst%0d state", i), 32'(a_state), 32'(2'b00));
    end
    tick();
    check_a("postrst final", 2'b10, 1, 1, 0, 0);
    drive_a(0, 0, 0, 0, 0);

    // PERSIST=1, CNT_W=2: every sample transitions; counters saturate at 3.
    b_seq    = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
    b_up_exp = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    b_dn_exp = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 8; i++) begin
      drive_b(1, b_seq[i] == 2'b01, b_seq[i] == 2'b10, b_seq[i] == 2'b00, 0);
      tick();
      check($sformatf("sat%0d state", i), 32'(b_state), 32'(b_seq[i]));
      check($sformatf("sat%0d pulse", i), 32'(b_pulse), 32'(1'b1));
      check($sformatf("sat%0d up", i),    32'(b_up),    32'(b_up_exp[i]));
      check($sformatf("sat%0d down", i),  32'(b_dn),    32'(b_dn_exp[i]));
    end
    drive_b(1, 0, 1, 0, 1);  // transition with clear
    tick();
    check("clrtr state", 32'(b_state), 32'(2'b10));
    check("clrtr pulse", 32'(b_pulse), 32'(1'b1));
    check("clrtr up",    32'(b_up),    32'(2'd0));
    check("clrtr down",  32'(b_dn),    32'(2'd0));
    drive_b(0, 0, 0, 0, 0);
    tick();
    check("b idle pulse", 32'(b_pulse), 32'(1'b0));
    drive_b(1, 0, 0, 1, 0);
    tick();
    check("b down after clr", 32'(b_dn), 32'(2'd1));
    check("b err", 32'(b_err), 32'(1'b0));
    drive_b(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
